// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared types and encodings for the MEM-stage load/store unit.
//   lsu_state_e  : request FSM states (IDLE, REQ, WAIT, DONE)
//   LSEL_* / SSEL_* : l_sel / s_sel encodings seen on the MEM-stage inputs
//   acc_size_e   : access width derived from the load/store type
//   load_size / store_size / misaligned : decode helpers
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LSEL_LB  = 3'b000;
  localparam logic [2:0] LSEL_LH  = 3'b001;
  localparam logic [2:0] LSEL_LW  = 3'b010;
  localparam logic [2:0] LSEL_LBU = 3'b100;
  localparam logic [2:0] LSEL_LHU = 3'b101;

  localparam logic [1:0] SSEL_SB  = 2'b00;
  localparam logic [1:0] SSEL_SH  = 2'b01;
  localparam logic [1:0] SSEL_SW  = 2'b10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Unlisted load codes behave as LW.
  function automatic acc_size_e load_size(input logic [2:0] l_sel);
    case (l_sel)
      LSEL_LB, LSEL_LBU: load_size = SZ_BYTE;
      LSEL_LH, LSEL_LHU: load_size = SZ_HALF;
      default:           load_size = SZ_WORD;
    endcase
  endfunction

  // s_sel 11 behaves as SW.
  function automatic acc_size_e store_size(input logic [1:0] s_sel);
    case (s_sel)
      SSEL_SB: store_size = SZ_BYTE;
      SSEL_SH: store_size = SZ_HALF;
      default: store_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input acc_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align -- combinational load extraction and sign/zero extension.
//   rdata_i  [31:0] raw word returned by data memory
//   offset_i [1:0]  byte offset of the access inside the word
//   l_sel_i  [2:0]  load type (LSEL_* encodings)
//   data_o   [31:0] extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  l_sel_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (l_sel_i)
      LSEL_LB:  data_o = {{24{byte_v[7]}}, byte_v};
      LSEL_LBU: data_o = {24'h000000, byte_v};
      LSEL_LH:  data_o = {{16{half_v[15]}}, half_v};
      LSEL_LHU: data_o = {16'h0000, half_v};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu -- MEM-stage load/store unit with a valid/ready data-memory port.
// Inputs : clk, rst_n (async, active-low), mem_rd_m, mem_wr_m, l_sel_m[2:0],
//          s_sel_m[1:0], alu_data_m[31:0] (byte address), write_data_m[31:0],
//          dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata[31:0]
// Outputs: dmem_req_valid/we/addr[31:0]/wdata[31:0]/be[3:0],
//          ld_data_w[31:0], ld_valid, stall_o, misalign_o
// Build option: LSU_MISALIGN_TRAP_EN -- when defined a misaligned access skips
// memory and pulses misalign_o; otherwise offending low address bits are cleared.
module mem_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd_m,
  input  logic        mem_wr_m,
  input  logic [2:0]  l_sel_m,
  input  logic [1:0]  s_sel_m,
  input  logic [31:0] alu_data_m,
  input  logic [31:0] write_data_m,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_be,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic [31:0] ld_data_w,
  output logic        ld_valid,
  output logic        stall_o,
  output logic        misalign_o
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  l_sel_q;
  logic [31:2] waddr_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        req_valid_q;
  logic        ld_valid_q;
  logic [31:0] ld_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_q;
  logic        trap_d;
`endif

  logic        req_present_d;
  acc_size_e   size_d;
  logic [1:0]  off_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ld_aligned;

  // Request decode. Store wins over load when both are raised. The offset is
  // forced to the access width's alignment, which only changes anything for a
  // misaligned access (the no-trap behaviour). Loads read the whole word.
  always_comb begin
    req_present_d = mem_rd_m | mem_wr_m;
    size_d        = mem_wr_m ? store_size(s_sel_m) : load_size(l_sel_m);
    case (size_d)
      SZ_HALF: off_d = {alu_data_m[1], 1'b0};
      SZ_WORD: off_d = '0;
      default: off_d = alu_data_m[1:0];
    endcase
    be_d    = '1;
    wdata_d = '0;
    if (mem_wr_m) begin
      case (size_d)
        SZ_BYTE: begin
          be_d    = 4'b0001 << off_d;
          wdata_d = {4{write_data_m[7:0]}};
        end
        SZ_HALF: begin
          be_d    = 4'b0011 << off_d;
          wdata_d = {2{write_data_m[15:0]}};
        end
        default: begin
          be_d    = '1;
          wdata_d = write_data_m;
        end
      endcase
    end
`ifdef LSU_MISALIGN_TRAP_EN
    trap_d = misaligned(size_d, alu_data_m[1:0]);
`endif
  end

  lsu_load_align u_load_align (
    .rdata_i  (dmem_rsp_rdata),
    .offset_i (off_q),
    .l_sel_i  (l_sel_q),
    .data_o   (ld_aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      l_sel_q     <= '0;
      waddr_q     <= '0;
      off_q       <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      req_valid_q <= 1'b0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      // Result and fault strobes are single-cycle pulses in DONE.
      ld_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_present_d) begin
            we_q    <= mem_wr_m;
            l_sel_q <= l_sel_m;
            waddr_q <= alu_data_m[31:2];
            off_q   <= off_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            if (trap_d) begin
              state_q    <= ST_DONE;
              misalign_q <= 1'b1;
            end else
`endif
            begin
              state_q     <= ST_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (dmem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem_rsp_valid) begin
            if (!we_q) begin
              ld_data_q  <= ld_aligned;
              ld_valid_q <= 1'b1;
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req_valid = req_valid_q;
  assign dmem_req_we    = we_q;
  assign dmem_req_addr  = {waddr_q, 2'b00};
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_be    = be_q;
  assign ld_data_w      = ld_data_q;
  assign ld_valid       = ld_valid_q;
  // Combinational in IDLE so the pipeline freezes in the same cycle a request appears.
  assign stall_o        = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                          ((state_q == ST_IDLE) && req_present_d);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_o     = misalign_q;
`else
  assign misalign_o     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu -- scoreboard bench for mem_lsu: directed cases plus randomized
// load/store traffic against a byte-array reference memory.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd_m, mem_wr_m;
  logic [2:0]  l_sel_m;
  logic [1:0]  s_sel_m;
  logic [31:0] alu_data_m, write_data_m;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic [31:0] ld_data_w;
  logic        ld_valid, stall_o, misalign_o;

  mem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd_m(mem_rd_m), .mem_wr_m(mem_wr_m), .l_sel_m(l_sel_m), .s_sel_m(s_sel_m),
    .alu_data_m(alu_data_m), .write_data_m(write_data_m),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .ld_data_w(ld_data_w), .ld_valid(ld_valid), .stall_o(stall_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        ldv;
    logic        mis;
    logic [31:0] data;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];

  int checks = 0;
  int fails  = 0;

  logic [7:0]  ref_mem[64];
  logic [31:0] env_mem[16];

  int fixed_rdy = 0;
  int fixed_rsp = 0;
  bit noise_en  = 1'b0;
  bit resp_en   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    env_mem[a[5:2]] = v;
    for (int i = 0; i < 4; i++) ref_mem[{a[5:2], 2'b00} + i] = v[8*i +: 8];
  endtask

  // Reference model: access width in bytes, misalignment as address modulo width,
  // memory as a flat byte array.
  task automatic model(input logic rd, input logic wr, input logic [2:0] lsel,
                       input logic [1:0] ssel, input logic [31:0] addr, input logic [31:0] data);
    int unsigned n, ea, v, lo;
    req_t  r;
    done_t d;
    logic  mis;
    if (wr)      n = (ssel == 2'd0) ? 1 : (ssel == 2'd1) ? 2 : 4;
    else if (rd) n = (lsel[1:0] == 2'd0) ? 1 : (lsel[1:0] == 2'd1) ? 2 : 4;
    else return;
    mis = (addr % n) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      d.ldv = 1'b0; d.mis = 1'b1; d.data = '0;
      done_q.push_back(d);
      return;
    end
`endif
    ea = addr - (addr % n);
    lo = ea % 4;
    r.addr = ea & ~32'd3;
    r.we = wr;
    r.be = '0;
    r.wdata = '0;
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= lo && i < lo + n) r.be[i] = 1'b1;
        r.wdata[8*i +: 8] = data[8*(i % n) +: 8];
      end
      for (int i = 0; i < n; i++) ref_mem[(ea + i) % 64] = data[8*i +: 8];
    end
    req_q.push_back(r);
    if (!wr) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(ea + i) % 64]) << (8*i));
      if (!lsel[2] && n < 4 && (((v >> (8*n - 1)) & 1) == 1))
        v = v | ~((32'd1 << (8*n)) - 1);
      d.ldv = 1'b1; d.mis = 1'b0; d.data = v;
      done_q.push_back(d);
    end
  endtask

  // Issue one MEM-stage request and hold it while stall_o is high.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] lsel,
                       input logic [1:0] ssel, input logic [31:0] addr,
                       input logic [31:0] data, output int stalls);
    @(negedge clk);
    model(rd, wr, lsel, ssel, addr, data);
    mem_rd_m = rd; mem_wr_m = wr; l_sel_m = lsel; s_sel_m = ssel;
    alu_data_m = addr; write_data_m = data;
    #1;
    stalls = 0;
    while (stall_o && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check("op_completes_in_budget", 32'(stalls < 200), 32'd1);
    mem_rd_m = 1'b0; mem_wr_m = 1'b0;
  endtask

  // Memory responder: random or fixed ready/response latency, optional noise on
  // ready/rsp_valid in states where the DUT must ignore them.
  initial begin : responder
    int n;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resp_en) continue;
      if (dmem_req_valid) begin
        n = (fixed_rdy >= 0) ? fixed_rdy : $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          dmem_req_ready = 1'b0;
          dmem_rsp_valid = noise_en && ($urandom_range(0, 1) == 0);
          @(negedge clk);
        end
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
        a = dmem_req_addr; we = dmem_req_we; be = dmem_req_be; wd = dmem_req_wdata;
        @(negedge clk);
        n = (fixed_rsp >= 0) ? fixed_rsp : $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          dmem_req_ready = noise_en && ($urandom_range(0, 1) == 0);
          dmem_rsp_valid = 1'b0;
          @(negedge clk);
        end
        dmem_req_ready = 1'b0;
        if (we) for (int i = 0; i < 4; i++) if (be[i]) env_mem[a[5:2]][8*i +: 8] = wd[8*i +: 8];
        dmem_rsp_rdata = we ? $urandom : env_mem[a[5:2]];
        dmem_rsp_valid = 1'b1;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = $urandom;
      end else begin
        dmem_req_ready = noise_en && ($urandom_range(0, 3) == 0);
        dmem_rsp_valid = noise_en && ($urandom_range(0, 3) == 0);
        dmem_rsp_rdata = $urandom;
      end
    end
  end

  // Monitor: compares the request payload whenever valid is up (which also
  // covers stability while ready is low) and every result/fault strobe.
  initial begin : monitor
    req_t  r;
    done_t d;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n !== 1'b1) continue;
      if (dmem_req_valid) begin
        check("req_expected", 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) begin
          r = req_q[0];
          check("req_addr", dmem_req_addr, r.addr);
          check("req_we", 32'(dmem_req_we), 32'(r.we));
          if (r.we) begin
            check("req_be", 32'(dmem_req_be), 32'(r.be));
            check("req_wdata", dmem_req_wdata, r.wdata);
          end
          if (dmem_req_ready) void'(req_q.pop_front());
        end
      end
      if (ld_valid || misalign_o) begin
        check("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          check("ld_valid", 32'(ld_valid), 32'(d.ldv));
          check("misalign_o", 32'(misalign_o), 32'(d.mis));
          if (d.ldv) check("ld_data_w", ld_data_w, d.data);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int    st;
    int    sel;
    req_t  r;
    rst_n = 1'b0;
    mem_rd_m = 1'b0; mem_wr_m = 1'b0; l_sel_m = '0; s_sel_m = '0;
    alu_data_m = '0; write_data_m = '0;
    for (int w = 0; w < 16; w++) set_word(32'h100 + 32'(w * 4), $urandom);

    #12;
    check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    check("rst_ld_valid", 32'(ld_valid), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_ld_data", ld_data_w, 32'd0);
    check("rst_req_addr", dmem_req_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LW with immediate ready and response.
    set_word(32'h100, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, 3'b010, 2'b00, 32'h100, 32'h0, st);
    check("lw_stall_cycles", 32'(st), 32'd3);
    check("lw_data", ld_data_w, 32'hDEADBEEF);

    // Sub-word load extension.
    set_word(32'h100, 32'h80FFFFFF);
    do_op(1'b1, 1'b0, 3'b000, 2'b00, 32'h103, 32'h0, st);
    check("lb_data", ld_data_w, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, 3'b100, 2'b00, 32'h103, 32'h0, st);
    check("lbu_data", ld_data_w, 32'h00000080);
    do_op(1'b1, 1'b0, 3'b101, 2'b00, 32'h102, 32'h0, st);
    check("lhu_data", ld_data_w, 32'h000080FF);

    // SB with ready withheld for three cycles.
    fixed_rdy = 3;
    do_op(1'b0, 1'b1, 3'b000, 2'b00, 32'h201, 32'h000000AB, st);
    check("sb_stall_cycles", 32'(st), 32'd6);
    check("sb_ld_data_kept", ld_data_w, 32'h000080FF);
    fixed_rdy = 0;

    // Misaligned SH.
    do_op(1'b0, 1'b1, 3'b000, 2'b01, 32'h203, 32'h00001234, st);
`ifdef LSU_MISALIGN_TRAP_EN
    check("sh_mis_stall_cycles", 32'(st), 32'd1);
`else
    check("sh_mis_stall_cycles", 32'(st), 32'd3);
`endif

    // Reset while waiting for the response; the late response must be dropped.
    resp_en = 1'b0;
    @(negedge clk);
    mem_rd_m = 1'b1; l_sel_m = 3'b010; alu_data_m = 32'h104;
    r.addr = 32'h104; r.we = 1'b0; r.be = '0; r.wdata = '0;
    req_q.push_back(r);
    @(negedge clk); #1;
    check("rstw_req_valid", 32'(dmem_req_valid), 32'd1);
    dmem_req_ready = 1'b1;
    @(negedge clk); #1;
    dmem_req_ready = 1'b0; mem_rd_m = 1'b0;
    check("rstw_wait_stall", 32'(stall_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstw_req_valid_low", 32'(dmem_req_valid), 32'd0);
    check("rstw_stall_low", 32'(stall_o), 32'd0);
    check("rstw_ld_data_zero", ld_data_w, 32'd0);
    check("rstw_ld_valid_low", 32'(ld_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    dmem_rsp_rdata = 32'h12345678; dmem_rsp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      dmem_rsp_valid = 1'b0;
      check("rstw_late_rsp_ld_valid", 32'(ld_valid), 32'd0);
      check("rstw_late_rsp_stall", 32'(stall_o), 32'd0);
    end
    resp_en = 1'b1;

    // Randomized traffic with random latencies and ignored-input noise.
    fixed_rdy = -1; fixed_rsp = -1; noise_en = 1'b1;
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end else begin
        do_op(sel <= 4 || sel == 9, sel >= 5, 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), 32'h100 + $urandom_range(0, 63), $urandom, st);
      end
    end
    noise_en = 1'b0;
    repeat (10) @(negedge clk);
    check("req_queue_drained", req_q.size(), 32'd0);
    check("done_queue_drained", done_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have MEM-stage inputs:
- mem_rd_m  in  1  load request
- mem_wr_m  in  1  store request
- l_sel_m  in  3  load type
- s_sel_m  in  2  store type
- alu_data_m  in  32  byte address
- write_data_m  in  32  store data
REQ-004 SHALL have the data-memory request channel:
- dmem_req_valid  out  1
- dmem_req_ready  in  1
- dmem_req_we  out  1
- dmem_req_addr  out  32  word-aligned, bits [1:0]=0
- dmem_req_wdata  out  32  lane-shifted
- dmem_req_be  out  4  byte enables
REQ-005 SHALL have the data-memory response channel: dmem_rsp_valid  in  1; dmem_rsp_rdata  in  32.
REQ-006 SHALL have pipeline-side outputs:
- ld_data_w  out  32  extended load result
- ld_valid  out  1  one-cycle result strobe
- stall_o  out  1  drives pipeline-register en low
- misalign_o  out  1  one-cycle fault pulse

Function
REQ-007 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-008 IDLE with mem_rd_m|mem_wr_m SHALL latch address, type, data and direction and go to REQ; if both are high, the store SHALL take priority.
REQ-009 REQ SHALL hold dmem_req_valid=1 with stable payload until dmem_req_ready=1, then go to WAIT.
REQ-010 WAIT SHALL hold until dmem_rsp_valid=1, then go to DONE. Loads capture rdata in that cycle; stores treat the response as the write acknowledgement.
REQ-011 DONE SHALL last exactly one cycle, then go to IDLE, and SHALL NOT re-sample the MEM inputs.
REQ-012 stall_o SHALL be 1 in REQ and WAIT, and in IDLE when a request is present; it SHALL be 0 in DONE and in an idle IDLE.
REQ-013 Minimum latency SHALL be 4 cycles from the request cycle in IDLE to DONE, with ready and response each arriving on first opportunity.
REQ-014 ld_valid SHALL be 1 only in DONE of a load. ld_data_w SHALL hold its value until the next load completes.
REQ-015 Load type codes and result:
- 000 LB, 100 LBU: byte at addr[1:0], sign-/zero-extended
- 001 LH, 101 LHU: half at addr[1], sign-/zero-extended
- 010 LW: word
- other codes SHALL be treated as LW
REQ-016 Store type codes, byte enables and data:
- 00 SB: be=0001<<addr[1:0]
- 01 SH: be=0011<<{addr[1],0}
- 10 SW: be=1111
- 11 SHALL be treated as SW
- wdata SHALL be the low bytes replicated to the enabled lanes
REQ-017 Misaligned access SHALL be: half access with addr[0]=1, or word access with addr[1:0]!=0.
REQ-018 dmem_rsp_valid SHALL be ignored outside WAIT, and dmem_req_ready SHALL be ignored outside REQ.

Reset
REQ-019 rst_n=0 SHALL immediately force state IDLE, dmem_req_valid=0, and all other outputs and latched fields 0, including mid-transaction.
REQ-020 A response arriving after reset release for an aborted transaction SHALL be discarded per REQ-018.

Configuration
REQ-021 Macro LSU_MISALIGN_TRAP_EN SHALL select misaligned-access handling.
- Defined: a misaligned request in IDLE SHALL go directly to DONE with no memory request, misalign_o=1 in that DONE, ld_valid=0, and stall_o=1 for the single IDLE cycle.
- Undefined: misalign_o SHALL be tied 0, and misaligned accesses SHALL proceed with offending low address bits cleared.

Structure
REQ-022 Package lsu_pkg SHALL hold the FSM state enum and the l_sel/s_sel encoding constants.
REQ-023 Load extraction and extension SHALL be the combinational sub-module lsu_load_align; store lane/byte-enable generation stays in mem_lsu.

Verification
REQ-024 LW addr 0x100, ready and rsp immediate, rdata 0xDEADBEEF -> dmem_req_addr 0x100, ld_valid in DONE, ld_data_w 0xDEADBEEF, stall_o high for 3 cycles.
REQ-025 LB addr 0x103, rdata 0x80FF_FFFF -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
REQ-026 SB addr 0x201, data 0x000000AB -> be 0010, wdata 0xABABABAB, we=1; ready held low 3 cycles -> payload stable, stall_o held.
REQ-027 SH addr 0x203 with LSU_MISALIGN_TRAP_EN -> no dmem_req_valid, misalign_o one cycle; without the macro -> addr 0x200, be 1100.
REQ-028 rst_n low in WAIT, then rsp_valid after release -> IDLE, no ld_valid, stall_o 0.
